// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - borrow_in, LSB first, behind a start/busy/done handshake
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CNT_W-1:0] cnt;
  logic             br, d, br_nxt, accept, last;
  always_comb begin
    d         = sa[0] ^ sb[0] ^ br;
    br_nxt    = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    accept    = start && state != SHIFT;
    last      = cnt == CNT_W'(WIDTH - 1);
    state_nxt = accept ? SHIFT : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
  end
  assign busy = state == SHIFT;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      br  <= borrow_in;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      br  <= br_nxt;
      cnt <= cnt + 1'b1;
      res <= {d, res[WIDTH-1:1]};
      if (last) begin
        diff       <= {d, res[WIDTH-1:1]};
        borrow_out <= br_nxt;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed table plus handshake corner sequences for serial_subtractor
module tb_serial_subtractor;
  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, borrow_in = 1'b0;
  logic [7:0] a = '0, b = '0, diff;
  logic       borrow_out, busy, done;
  int         n_cmp = 0, n_err = 0;

  typedef struct {
    logic [7:0] a, b;
    logic       bin;
    logic [7:0] exp_d;
    logic       exp_bo;
  } vec_t;
  vec_t vecs[8];

  serial_subtractor #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .diff(diff), .borrow_out(borrow_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic start_op(input logic [7:0] va, input logic [7:0] vb, input logic vbin);
    a = va; b = vb; borrow_in = vbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~va; b = ~vb; borrow_in = ~vbin;
  endtask

  // Called one negedge after start_op; pulses a second start at sample inj (0 = never).
  task automatic wait_done(input string nm, input logic [7:0] exp_d, input logic exp_bo, input int inj);
    int j = 1, nb = 0;
    while (!done && j < 30) begin
      if (busy) nb++;
      if (j == inj) begin a = 8'h11; b = 8'h22; borrow_in = 1'b1; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk);
      j++;
    end
    start = 1'b0;
    chk({nm, " latency"}, j, 9);
    chk({nm, " busy_cycles"}, nb, 8);
    chk({nm, " busy_at_done"}, int'(busy), 0);
    chk({nm, " diff"}, int'(diff), int'(exp_d));
    chk({nm, " borrow_out"}, int'(borrow_out), int'(exp_bo));
  endtask

  task automatic count_done(input string nm, input int cycles);
    int nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk({nm, " extra_done"}, nd, 0);
  endtask

  initial begin
    logic [8:0] m;
    logic [7:0] ra, rb;
    logic       rbin;
    vecs[0] = '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0};
    vecs[1] = '{8'd0,   8'd1,   1'b0, 8'hFF,  1'b1};
    vecs[2] = '{8'h80,  8'h80,  1'b1, 8'hFF,  1'b1};
    vecs[3] = '{8'h55,  8'h55,  1'b0, 8'h00,  1'b0};
    vecs[4] = '{8'h00,  8'h00,  1'b1, 8'hFF,  1'b1};
    vecs[5] = '{8'hFF,  8'h00,  1'b1, 8'hFE,  1'b0};
    vecs[6] = '{8'h01,  8'hFF,  1'b0, 8'h02,  1'b1};
    vecs[7] = '{8'h7F,  8'h80,  1'b0, 8'hFF,  1'b1};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset diff", int'(diff), 0);
    chk("reset borrow_out", int'(borrow_out), 0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      wait_done($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_bo, 0);
      @(negedge clk);
      chk($sformatf("vec%0d hold_diff", i), int'(diff), int'(vecs[i].exp_d));
    end

    start_op(8'd50, 8'd20, 1'b0);
    wait_done("ignore_start", 8'd30, 1'b0, 3);
    count_done("ignore_start", 12);

    start_op(8'd9, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset busy", int'(busy), 0);
    chk("midreset done", int'(done), 0);
    chk("midreset diff", int'(diff), 0);
    chk("midreset borrow_out", int'(borrow_out), 0);
    count_done("midreset", 12);
    start_op(8'd9, 8'd3, 1'b0);
    wait_done("after_reset", 8'd6, 1'b0, 0);

    start_op(8'd200, 8'd55, 1'b0);
    chk("b2b busy", int'(busy), 1);
    chk("b2b diff_hold", int'(diff), 6);
    wait_done("b2b", 8'd145, 1'b0, 0);
    start_op(8'd3, 8'd5, 1'b1);
    wait_done("b2b2", 8'hFD, 1'b1, 0);
    @(negedge clk);

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom_range(255)); rb = 8'($urandom_range(255)); rbin = 1'($urandom_range(1));
      m = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
      start_op(ra, rb, rbin);
      wait_done($sformatf("rand%0d", i), m[7:0], m[8], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
